// File: rtl/col_scheduler_if.sv
// rtl/col_scheduler_if.sv - control, line-buffer, engine and output-buffer signals of col_scheduler
//
// Purpose: bundles every non-clock/reset signal of col_scheduler.
//   slave  : the scheduler side (drives status, read, engine and write strobes)
//   master : the surrounding side (drives start and proc_result)
// Signals:
//   start, busy, done, err                        frame control and status
//   rd_en, rd_col[7:0], rd_row[8:0]               line-buffer read
//   proc_en, proc_iter, proc_bank_en, proc_result engine control and result strobe
//   wr_en, wr_col[7:0], wr_idx[7:0]               output-buffer write
interface col_scheduler_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic       rd_en;
    logic [7:0] rd_col;
    logic [8:0] rd_row;
    logic       proc_en;
    logic       proc_iter;
    logic       proc_bank_en;
    logic       proc_result;
    logic       wr_en;
    logic [7:0] wr_col;
    logic [7:0] wr_idx;

    modport slave (
        input  start, proc_result,
        output busy, done, err, rd_en, rd_col, rd_row,
               proc_en, proc_iter, proc_bank_en, wr_en, wr_col, wr_idx
    );

    modport master (
        output start, proc_result,
        input  busy, done, err, rd_en, rd_col, rd_row,
               proc_en, proc_iter, proc_bank_en, wr_en, wr_col, wr_idx
    );
endinterface

// File: rtl/col_scheduler.sv
// rtl/col_scheduler.sv - frame-level column sequencer for the column lifting engine
//
// Purpose: on start, walks NUM_COLS columns; per column launches the engine,
// streams LENGTH row reads, then drains result pairs (bounded by DRAIN_MAX
// cycles, sticky err on timeout) and writes each accepted pair to the output buffer.
// Ports:
//   i_clk    clock, rising edge
//   i_reset  synchronous active-high reset, dominant
//   bus      col_scheduler_if.slave (see interface file for signal list)
module col_scheduler #(
    parameter int LENGTH    = 256,
    parameter int NUM_COLS  = 64,
    parameter int DRAIN_MAX = 16
) (
    input  logic           i_clk,
    input  logic           i_reset,
    col_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_STREAM, S_DRAIN, S_NEXT, S_FIN
    } state_t;

    localparam logic [8:0]  K_LAST   = 9'(LENGTH - 1);
    localparam logic [7:0]  HALF     = 8'(LENGTH / 2);
    localparam logic [7:0]  COL_LAST = 8'(NUM_COLS - 1);
    localparam logic [15:0] TMR_LAST = 16'(DRAIN_MAX - 1);

    state_t      r_state, w_state;
    logic [7:0]  r_col,   w_col;
    logic [8:0]  r_k,     w_k;
    logic [7:0]  r_pairs, w_pairs;
    logic [15:0] r_timer, w_timer;
    logic        r_err,   w_err;

    logic        w_capture;
    logic        w_accept;
    logic        w_complete;
    logic        w_rd_en;
    logic [8:0]  w_rd_row;
    logic        w_proc_en;
    logic        w_proc_iter;
    logic        w_bank_en;
    logic        w_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_k     <= '0;
            r_pairs <= '0;
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_col   <= w_col;
            r_k     <= w_k;
            r_pairs <= w_pairs;
            r_timer <= w_timer;
            r_err   <= w_err;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_col       = r_col;
        w_k         = r_k;
        w_pairs     = r_pairs;
        w_timer     = r_timer;
        w_err       = r_err;
        w_rd_en     = 1'b0;
        w_rd_row    = '0;
        w_proc_en   = 1'b0;
        w_proc_iter = 1'b0;
        w_bank_en   = 1'b0;
        w_done      = 1'b0;

        // Results are only captured while a column is in flight, and the
        // pair count saturates so surplus strobes are dropped.
        w_capture = (r_state == S_LAUNCH) || (r_state == S_STREAM) || (r_state == S_DRAIN);
        w_accept  = w_capture && bus.proc_result && (r_pairs != HALF);
        if (w_accept) begin
            w_pairs = r_pairs + 8'd1;
        end
        // Includes this cycle's result, so a pair landing on the last drain
        // cycle completes the column instead of timing out.
        w_complete = (w_pairs == HALF);

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state = S_LAUNCH;
                    w_col   = '0;
                    w_err   = 1'b0;
                end
            end
            S_LAUNCH: begin
                w_proc_en = 1'b1;
                w_rd_en   = 1'b1;
                w_k       = 9'd1;
                w_state   = S_STREAM;
            end
            S_STREAM: begin
                w_rd_en     = 1'b1;
                w_rd_row    = r_k;
                w_bank_en   = 1'b1;
                w_proc_iter = 1'b1;
                w_k         = r_k + 9'd1;
                if (r_k == K_LAST) begin
                    w_state = S_DRAIN;
                    w_timer = '0;
                end
            end
            S_DRAIN: begin
                w_proc_iter = 1'b1;
                w_timer     = r_timer + 16'd1;
                if (w_complete) begin
                    w_state = S_NEXT;
                end else if (r_timer == TMR_LAST) begin
                    w_state = S_NEXT;
                    w_err   = 1'b1;
                end
            end
            S_NEXT: begin
                w_pairs = '0;
                if (r_col == COL_LAST) begin
                    w_state = S_FIN;
                end else begin
                    w_col   = r_col + 8'd1;
                    w_state = S_LAUNCH;
                end
            end
            S_FIN: begin
                w_done  = 1'b1;
                // Parks col at 0 so rd_col/wr_col read 0 while idle.
                w_col   = '0;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.busy         = (r_state != S_IDLE) && (r_state != S_FIN);
    assign bus.done         = w_done;
    assign bus.err          = r_err;
    assign bus.rd_en        = w_rd_en;
    assign bus.rd_col       = r_col;
    assign bus.rd_row       = w_rd_row;
    assign bus.proc_en      = w_proc_en;
    assign bus.proc_iter    = w_proc_iter;
    assign bus.proc_bank_en = w_bank_en;
    assign bus.wr_en        = w_accept;
    assign bus.wr_col       = r_col;
    assign bus.wr_idx       = r_pairs;
endmodule
